// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - byte-serial instruction window fetch sequencer
// Gathers INSTR_BYTES bytes from a combinational memory, then holds the window until the decoder acks.
module fetch_seq #(
  parameter int          IMEM_SIZE   = 256,
  parameter int          INSTR_BYTES = 10,
  parameter logic [63:0] RESET_PC    = 64'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [63:0]              imem_addr,
  output logic                     imem_rd,
  input  logic [7:0]               imem_data,
  output logic [INSTR_BYTES*8-1:0] instr,
  output logic                     instr_valid,
  input  logic                     instr_ack,
  input  logic [63:0]              valP,
  input  logic                     halt,
  input  logic                     invalid_instr,
  input  logic                     mem_error,
  input  logic                     redirect_en,
  input  logic [63:0]              redirect_pc,
  output logic [63:0]              pc,
  output logic [2:0]               state,
  output logic [15:0]              retired
);

  localparam int CNT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INSTR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READY  = 3'd2,
    S_HALTED = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t           cur, nxt;
  logic [CNT_W-1:0] byte_cnt, cnt_nxt;
  logic [63:0]      pc_nxt;
  logic [64:0]      addr_sum;
  logic             in_range;
  logic             capture;
  logic             retire;
  logic [7:0]       byte_val;

  // A carry out of pc+byte_cnt means the address wrapped, which is never a valid memory byte.
  assign addr_sum    = {1'b0, pc} + 65'(byte_cnt);
  assign in_range    = ~addr_sum[64] && (addr_sum[63:0] < 64'(IMEM_SIZE));
  assign imem_addr   = addr_sum[63:0];
  assign byte_val    = imem_rd ? imem_data : 8'h00;
  assign instr_valid = (cur == S_READY);
  assign state       = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt     = cur;
    pc_nxt  = pc;
    cnt_nxt = byte_cnt;
    imem_rd = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (cur)
      S_IDLE: nxt = S_LOAD;
      S_LOAD: begin
        imem_rd = in_range;
        if (redirect_en) begin
          pc_nxt  = redirect_pc;
          cnt_nxt = '0;
        end else if (byte_cnt == '0 && !in_range) begin
          nxt = S_ERROR;
        end else begin
          capture = 1'b1;
          if (byte_cnt == LAST_CNT) begin
            cnt_nxt = '0;
            nxt     = S_READY;
          end else begin
            cnt_nxt = byte_cnt + 1'b1;
          end
        end
      end
      S_READY: begin
        if (instr_ack) begin
          if (halt) begin
            nxt = S_HALTED;
          end else if (mem_error) begin
            nxt = S_ERROR;
          end else begin
            nxt    = S_LOAD;
            retire = 1'b1;
            if (invalid_instr)    pc_nxt = pc + 64'd1;
            else if (redirect_en) pc_nxt = redirect_pc;
            else                  pc_nxt = valP;
          end
        end
      end
      default: nxt = cur;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      byte_cnt <= '0;
      instr    <= '0;
      retired  <= 16'd0;
    end else begin
      pc       <= pc_nxt;
      byte_cnt <= cnt_nxt;
      if (retire) retired <= retired + 16'd1;
      for (int i = 0; i < INSTR_BYTES; i++) begin
        if (capture && byte_cnt == CNT_W'(i)) instr[i*8 +: 8] <= byte_val;
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - self-checking bench for fetch_seq
module tb_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic        imem_rd;
  logic [7:0]  imem_data;
  logic [79:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [63:0] valP;
  logic        halt;
  logic        invalid_instr;
  logic        mem_error;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] pc;
  logic [2:0]  state;
  logic [15:0] retired;

  logic [7:0]  mem [256];
  int          checks;
  int          failures;

  fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
    .instr_ack(instr_ack), .valP(valP), .halt(halt), .invalid_instr(invalid_instr),
    .mem_error(mem_error), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .pc(pc), .state(state), .retired(retired)
  );

  // Out-of-range addresses return junk so a capture that ignores imem_rd shows up.
  assign imem_data = (imem_addr < 64'd256) ? mem[imem_addr[7:0]] : 8'hEE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] start;
    logic        h, me, inv, rd;
    logic [63:0] rpc, vp;
    logic [2:0]  st;
    logic [63:0] npc;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] exp_window(input logic [63:0] s);
    logic [79:0] w;
    logic [63:0] a;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      a = s + 64'(i);
      w[i*8 +: 8] = (a < 64'd256) ? mem[a[7:0]] : 8'h00;
    end
    return w;
  endfunction

  task automatic clear_in();
    instr_ack = 0; halt = 0; invalid_instr = 0; mem_error = 0;
    redirect_en = 0; redirect_pc = '0; valP = '0;
  endtask

  // Leaves the DUT in its first LOAD cycle at RESET_PC.
  task automatic do_reset();
    clear_in();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic start_at(input logic [63:0] p);
    redirect_en = 1; redirect_pc = p;
    tick();
    redirect_en = 0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    chk(name, {79'd0, instr_valid}, 80'd1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    do_reset();
    start_at(v.start);
    wait_valid($sformatf("v%0d_valid", k));
    chk($sformatf("v%0d_pc", k), {16'd0, pc}, {16'd0, v.start});
    chk($sformatf("v%0d_instr", k), instr, exp_window(v.start));
    instr_ack = 1; halt = v.h; mem_error = v.me; invalid_instr = v.inv;
    redirect_en = v.rd; redirect_pc = v.rpc; valP = v.vp;
    tick();
    clear_in();
    chk($sformatf("v%0d_state", k), {77'd0, state}, {77'd0, v.st});
    chk($sformatf("v%0d_npc", k), {16'd0, pc}, {16'd0, v.npc});
    chk($sformatf("v%0d_retired", k), {64'd0, retired}, {64'd0, v.ret});
    if (v.st == 3'd1) chk($sformatf("v%0d_addr", k), {16'd0, imem_addr}, {16'd0, v.npc});
  endtask

  task automatic run_program();
    logic [63:0] seen [$];
    logic [63:0] tgt;
    logic [7:0]  op;
    int          n;
    logic [63:0] exp_seq [5];
    exp_seq = '{64'd0, 64'd1, 64'd3, 64'd13, 64'd14};
    do_reset();
    n = 0;
    while (state != 3'd3 && n < 300) begin
      clear_in();
      if (instr_valid) begin
        seen.push_back(pc);
        op = mem[pc[7:0]];
        instr_ack = 1;
        case (op[7:4])
          4'h0: halt = 1;
          4'h1: valP = pc + 64'd1;
          4'h6: valP = pc + 64'd2;
          4'h7: begin
            for (int b = 0; b < 8; b++) tgt[b*8 +: 8] = mem[pc[7:0] + 8'(b + 1)];
            redirect_en = 1; redirect_pc = tgt;
          end
          default: invalid_instr = 1;
        endcase
      end
      tick();
      n++;
    end
    clear_in();
    chk("prog_count", 80'(seen.size()), 80'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("prog_pc%0d", i), (i < seen.size()) ? {16'd0, seen[i]} : {80{1'b1}}, {16'd0, exp_seq[i]});
    chk("prog_state", {77'd0, state}, 80'd3);
    chk("prog_final_pc", {16'd0, pc}, 80'd14);
    chk("prog_retired", {64'd0, retired}, 80'd4);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
    mem[0] = 8'h10; mem[1] = 8'h60; mem[2] = 8'h9A; mem[3] = 8'h70;
    mem[4] = 8'h0D;
    for (int i = 5; i < 12; i++) mem[i] = 8'h00;
    mem[12] = 8'h00; mem[13] = 8'h10; mem[14] = 8'h00;

    //            start  h  me inv rd  rpc     valP    st    npc     ret
    vecs[0] = '{64'd0,   0, 0, 0, 0, 64'd0,  64'h20, 3'd1, 64'h20, 16'd1};
    vecs[1] = '{64'd5,   0, 0, 1, 0, 64'd0,  64'h77, 3'd1, 64'd6,  16'd1};
    vecs[2] = '{64'd5,   0, 1, 1, 0, 64'd0,  64'h77, 3'd4, 64'd5,  16'd0};
    vecs[3] = '{64'd7,   1, 1, 1, 1, 64'h50, 64'h77, 3'd3, 64'd7,  16'd0};
    vecs[4] = '{64'd9,   0, 1, 0, 1, 64'h50, 64'h77, 3'd4, 64'd9,  16'd0};
    vecs[5] = '{64'd20,  0, 0, 0, 1, 64'h40, 64'h99, 3'd1, 64'h40, 16'd1};
    vecs[6] = '{64'd250, 0, 0, 0, 0, 64'd0,  64'h11, 3'd1, 64'h11, 16'd1};
    vecs[7] = '{64'd3,   0, 0, 1, 1, 64'h50, 64'h77, 3'd1, 64'd4,  16'd1};

    clear_in();
    rst_n = 0;
    tick();
    chk("rst_state", {77'd0, state}, 80'd0);
    chk("rst_pc", {16'd0, pc}, 80'd0);
    chk("rst_instr", instr, 80'd0);
    chk("rst_valid", {79'd0, instr_valid}, 80'd0);
    chk("rst_rd", {79'd0, imem_rd}, 80'd0);
    chk("rst_retired", {64'd0, retired}, 80'd0);
    rst_n = 1;
    tick();
    chk("idle_to_load", {77'd0, state}, 80'd1);

    for (int k = 0; k < 8; k++) run_vec(k);

    run_program();

    // Stall: no ack for five READY cycles.
    do_reset();
    start_at(64'd30);
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d", i), {instr_valid, imem_rd, 14'd0, pc[63:0]} ^ {instr, 80'd0} >> 80,
          {1'b1, 1'b0, 14'd0, 64'd30} ^ {exp_window(64'd30), 80'd0} >> 80);
      chk($sformatf("stall%0d_instr", i), instr, exp_window(64'd30));
    end

    // Window straddling the end of memory, then a load starting past it.
    do_reset();
    start_at(64'd250);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("edge_rd%0d", k), {79'd0, imem_rd}, (k < 6) ? 80'd1 : 80'd0);
      tick();
    end
    chk("edge_state", {77'd0, state}, 80'd2);
    chk("edge_instr", instr, exp_window(64'd250));
    do_reset();
    start_at(64'd256);
    chk("oob_rd", {79'd0, imem_rd}, 80'd0);
    tick();
    chk("oob_state", {77'd0, state}, 80'd4);
    instr_ack = 1; redirect_en = 1; redirect_pc = 64'd0;
    tick();
    tick();
    clear_in();
    chk("err_terminal", {77'd0, state}, 80'd4);
    chk("err_rd", {79'd0, imem_rd}, 80'd0);

    // Redirect mid-load.
    do_reset();
    start_at(64'd0);
    repeat (4) tick();
    redirect_en = 1; redirect_pc = 64'd13;
    tick();
    redirect_en = 0;
    chk("redir_addr", {16'd0, imem_addr}, 80'd13);
    chk("redir_state", {77'd0, state}, 80'd1);
    begin
      int n;
      n = 0;
      while (!instr_valid && n < 30) begin
        tick();
        n++;
      end
      chk("redir_cycles", 80'(n), 80'd10);
    end
    chk("redir_instr", instr, exp_window(64'd13));
    chk("redir_pc", {16'd0, pc}, 80'd13);

    // Asynchronous reset while READY.
    do_reset();
    start_at(64'd40);
    wait_valid("ar_valid0");
    rst_n = 0;
    #1;
    chk("ar_valid", {79'd0, instr_valid}, 80'd0);
    chk("ar_pc", {16'd0, pc}, 80'd0);
    chk("ar_instr", instr, 80'd0);
    tick();
    rst_n = 1;
    #1;
    chk("ar_idle", {77'd0, state}, 80'd0);
    tick();
    chk("ar_load", {77'd0, state}, 80'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter IMEM_SIZE, default 256, instruction memory depth in bytes.
REQ-002 Parameter INSTR_BYTES, default 10, bytes gathered per instruction window.
REQ-003 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_addr  output  64  byte address to instruction memory, = pc + byte_cnt.
REQ-007 imem_rd  output  1  read strobe; memory returns data combinationally in the same cycle.
REQ-008 imem_data  input  8  byte read from imem_addr.
REQ-009 instr  output  80  assembled window, bits [0:7] = byte at pc, bits [72:79] = byte at pc+9.
REQ-010 instr_valid  output  1  instr and pc are stable and may be decoded.
REQ-011 instr_ack  input  1  fetch decoder consumed the window; sampled only when instr_valid=1.
REQ-012 valP  input  64  next sequential PC from fetch decode.
REQ-013 halt, invalid_instr, mem_error  input  1 each  decode status for current window.
REQ-014 redirect_en  input  1, redirect_pc  input  64  taken-branch/jump target request.
REQ-015 pc  output  64  address of current window.
REQ-016 state  output  3  encoded FSM state (IDLE=0, LOAD=1, READY=2, HALTED=3, ERROR=4).
REQ-017 retired  output  16  count of windows acknowledged without halt/error.

Function
REQ-018 FSM SHALL have states IDLE, LOAD, READY, HALTED, ERROR; IDLE lasts exactly one cycle then goes to LOAD.
REQ-019 On LOAD entry byte_cnt SHALL be 0; if pc >= IMEM_SIZE, next state SHALL be ERROR with no read issued.
REQ-020 In LOAD, each cycle: imem_rd=1 iff pc+byte_cnt < IMEM_SIZE; captured byte = imem_data if read, else 8'h00; byte_cnt increments.
REQ-021 LOAD SHALL take exactly INSTR_BYTES cycles; after byte INSTR_BYTES-1 is captured, next state READY, byte_cnt cleared.
REQ-022 imem_rd SHALL be 0 in every state other than LOAD.
REQ-023 instr_valid SHALL be 1 only in READY; instr and pc SHALL not change while in READY.
REQ-024 In READY with instr_ack=1, priority: halt -> HALTED; else mem_error -> ERROR; else invalid_instr -> pc<=pc+1, LOAD; else redirect_en -> pc<=redirect_pc, LOAD; else pc<=valP, LOAD.
REQ-025 retired SHALL increment (wrapping 16'hFFFF -> 0) on each ack taking the invalid_instr, redirect or valP branch only.
REQ-026 redirect_en=1 during LOAD SHALL abort the load: pc<=redirect_pc, byte_cnt<=0, stay in LOAD; partial bytes discarded.
REQ-027 redirect_en, instr_ack and status inputs SHALL be ignored in IDLE, HALTED, ERROR.
REQ-028 HALTED and ERROR SHALL be terminal until rst_n asserted.
REQ-029 PC arithmetic SHALL be 64-bit unsigned, wrapping modulo 2^64; pc+byte_cnt overflow SHALL be treated as >= IMEM_SIZE.
REQ-030 Back-to-back: ack in READY cycle N SHALL give first LOAD read at cycle N+1 at the new pc.

Reset
REQ-031 While rst_n=0: state=IDLE, pc=RESET_PC, byte_cnt=0, instr=0, instr_valid=0, imem_rd=0, retired=0.
REQ-032 rst_n assertion mid-LOAD or mid-READY SHALL immediately (asynchronously) force all reset values; partial window discarded.

Verification
REQ-033 Memory: 0:10, 1:60 9A, 3:70 + 64-bit 13, 12:00, 13:10, 14:00; ack every READY, drive valP/redirect from a fetch model -> pc sequence 0,1,3,13,14; HALTED at pc=14; retired=4.
REQ-034 Hold instr_ack=0 for 5 READY cycles -> instr_valid stays 1, instr/pc unchanged, imem_rd=0 throughout.
REQ-035 pc=250, IMEM_SIZE=256 -> bytes 250..255 read, instr bytes 6..9 = 00, imem_rd=0 for last 4 LOAD cycles; pc=256 -> ERROR, no read.
REQ-036 Ack with invalid_instr=1 at pc=5 -> next LOAD at pc=6; with invalid_instr=1 and mem_error=1 -> ERROR.
REQ-037 redirect_en=1 (redirect_pc=13) at LOAD byte_cnt=4 -> next cycle imem_addr=13, LOAD completes 10 cycles later.
REQ-038 rst_n low during READY -> instr_valid=0, pc=RESET_PC same cycle; IDLE one cycle after release, then LOAD.
